// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : MIPS instruction-fetch stage: PC, icache handshake, IF/ID latch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        fetch_halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [31:0] c_pc_step = 32'd4;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_ifid_instr, w_ifid_instr;
    logic [31:0] r_ifid_npc, w_ifid_npc;
    logic        r_ifid_valid, w_ifid_valid;
    logic [31:0] r_hold_instr, w_hold_instr;
    logic [31:0] r_hold_npc, w_hold_npc;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4   = r_pc + c_pc_step;
    assign imemaddr     = r_pc;
    assign imemREN      = (r_state == FETCH);
    assign fetch_halted = (r_state == HALTED);
    assign ifid_instr   = r_ifid_instr;
    assign ifid_npc     = r_ifid_npc;
    assign ifid_valid   = r_ifid_valid;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= FETCH;
            r_pc         <= PC_INIT;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_npc   <= 32'd0;
            r_ifid_valid <= 1'b0;
            r_hold_instr <= 32'd0;
            r_hold_npc   <= 32'd0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_ifid_instr <= w_ifid_instr;
            r_ifid_npc   <= w_ifid_npc;
            r_ifid_valid <= w_ifid_valid;
            r_hold_instr <= w_hold_instr;
            r_hold_npc   <= w_hold_npc;
        end
    end

    // Priority: redirect > halt > stall > ihit. A bubble leaves npc untouched.
    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_ifid_instr = r_ifid_instr;
        w_ifid_npc   = r_ifid_npc;
        w_ifid_valid = r_ifid_valid;
        w_hold_instr = r_hold_instr;
        w_hold_npc   = r_hold_npc;

        if (redirect_en) begin
            w_state      = FETCH;
            w_pc         = redirect_pc & ~32'h3;
            w_ifid_instr = NOP_INSTR;
            w_ifid_valid = 1'b0;
            w_hold_instr = 32'd0;
            w_hold_npc   = 32'd0;
        end else if (halt) begin
            w_state = HALTED;
            if (!stall) begin
                w_ifid_instr = NOP_INSTR;
                w_ifid_valid = 1'b0;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (stall) begin
                        if (ihit) begin
                            // Park the returned word so it is neither lost nor refetched.
                            w_hold_instr = iload;
                            w_hold_npc   = w_pc_plus4;
                            w_pc         = w_pc_plus4;
                            w_state      = HOLD;
                        end
                    end else if (ihit) begin
                        w_ifid_instr = iload;
                        w_ifid_npc   = w_pc_plus4;
                        w_ifid_valid = 1'b1;
                        w_pc         = w_pc_plus4;
                    end else begin
                        w_ifid_instr = NOP_INSTR;
                        w_ifid_valid = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_ifid_instr = r_hold_instr;
                        w_ifid_npc   = r_hold_npc;
                        w_ifid_valid = 1'b1;
                        w_state      = FETCH;
                    end
                end
                HALTED: begin
                    if (!stall) begin
                        w_ifid_instr = NOP_INSTR;
                        w_ifid_valid = 1'b0;
                    end
                end
                default: begin
                    w_state = FETCH;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage (IF/ID words queued at drive time).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'd0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        fetch_halted;

    int total = 0;
    int bad   = 0;

    logic [63:0] sb_q[$];

    fetch_stage #(
        .PC_INIT  (32'h00000000),
        .NOP_INSTR(32'h00000000)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .iload       (iload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ifid_instr  (ifid_instr),
        .ifid_npc    (ifid_npc),
        .ifid_valid  (ifid_valid),
        .fetch_halted(fetch_halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] npc);
        sb_q.push_back({instr, npc});
    endtask

    // Unstalled edge with valid=1 afterwards means a fresh word entered IF/ID.
    always @(posedge CLK) begin
        logic s;
        s = stall;
        #1;
        if (nRST && !s && ifid_valid) begin
            if (sb_q.size() == 0)
                chk("ifid_unexpected", {ifid_instr, ifid_npc}, 64'h0);
            else
                chk("ifid_word", {ifid_instr, ifid_npc}, sb_q.pop_front());
        end
    end

    initial begin
        logic [31:0] held;
        #2;
        chk("rst_instr", ifid_instr, 0);
        chk("rst_npc",   ifid_npc, 0);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_halted", fetch_halted, 0);
        chk("rst_addr",  imemaddr, 0);
        step();
        nRST = 1'b1;
        chk("rst_ren", imemREN, 1);

        // Straight-line fetch of three words.
        ihit = 1'b1;
        iload = 32'h20010001; push(iload, 32'h4); step();
        chk("addr_4", imemaddr, 32'h4);
        iload = 32'h20020002; push(iload, 32'h8); step();
        chk("addr_8", imemaddr, 32'h8);
        iload = 32'h00221820; push(iload, 32'hC); step();
        chk("addr_c", imemaddr, 32'hC);

        // ihit under stall goes to the hold buffer.
        stall = 1'b1;
        iload = 32'h8C230000; step();
        held = 32'h8C230000;
        iload = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            chk("hold_ren", imemREN, 0);
            chk("hold_addr", imemaddr, 32'h10);
            chk("hold_ifid", ifid_instr, 32'h00221820);
            if (i < 2) step();
        end
        stall = 1'b0;
        ihit = 1'b0;
        push(held, 32'h10); step();
        chk("unhold_addr", imemaddr, 32'h10);
        chk("unhold_ren", imemREN, 1);

        // Miss: address held, bubbles into IF/ID.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("miss_ren", imemREN, 1);
            chk("miss_addr", imemaddr, 32'h10);
            chk("miss_valid", ifid_valid, 0);
            chk("miss_instr", ifid_instr, 32'h0);
        end

        ihit = 1'b1;
        iload = 32'h11111111; push(iload, 32'h14); step();

        // Redirect discards the same-cycle word and masks low bits.
        iload = 32'hBADBAD14;
        redirect_en = 1'b1; redirect_pc = 32'h00000043; step();
        redirect_en = 1'b0;
        chk("redir_addr", imemaddr, 32'h40);
        chk("redir_valid", ifid_valid, 0);
        iload = 32'h22222222; push(iload, 32'h44); step();
        chk("post_redir_addr", imemaddr, 32'h44);

        // Halt freezes the PC and drops the same-cycle word.
        iload = 32'h33333333;
        halt = 1'b1; step();
        for (int i = 0; i < 2; i++) begin
            chk("halt_flag", fetch_halted, 1);
            chk("halt_ren", imemREN, 0);
            chk("halt_addr", imemaddr, 32'h44);
            chk("halt_valid", ifid_valid, 0);
            step();
        end

        // Redirect wins over a simultaneous halt.
        redirect_en = 1'b1; redirect_pc = 32'h00000100; step();
        redirect_en = 1'b0; halt = 1'b0;
        chk("unhalt_flag", fetch_halted, 0);
        chk("unhalt_ren", imemREN, 1);
        chk("unhalt_addr", imemaddr, 32'h100);
        iload = 32'h44444444; push(iload, 32'h104); step();

        // PC+4 wraps to zero.
        redirect_en = 1'b1; redirect_pc = 32'hFFFFFFFE; step();
        redirect_en = 1'b0;
        chk("wrap_pre", imemaddr, 32'hFFFFFFFC);
        iload = 32'h55555555; push(iload, 32'h0); step();
        chk("wrap_addr", imemaddr, 32'h0);

        // Async reset asserted while in HOLD.
        stall = 1'b1; iload = 32'h66666666; step();
        chk("hold2_ren", imemREN, 0);
        chk("hold2_valid", ifid_valid, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_addr", imemaddr, 32'h0);
        chk("arst_ren", imemREN, 1);
        chk("arst_valid", ifid_valid, 0);
        chk("arst_instr", ifid_instr, 32'h0);
        chk("arst_halted", fetch_halted, 0);
        stall = 1'b0; ihit = 1'b0;
        step();
        nRST = 1'b1;
        step();
        chk("arst_post_addr", imemaddr, 32'h0);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
